// File: rtl/VX_raster_pkg.sv
// Shared raster types: the stamp record, the packer state encoding and the
// lane-count helper used by the emitted-stamp performance counter.
package VX_raster_pkg;

  localparam int MAX_LANES = 32;

  typedef struct packed {
    logic [11:0] pos_x;
    logic [11:0] pos_y;
    logic [3:0]  mask;
    logic [7:0]  pid;
  } raster_stamp_t;

  typedef enum logic [1:0] {
    FILL,
    FLUSH,
    DONE
  } packer_state_t;

  // Number of set bits in a per-lane "mask is non-zero" vector.
  function automatic logic [5:0] lane_count(input logic [MAX_LANES-1:0] active);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n += 6'(active[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/VX_raster_bus_if.sv
// Request channel from a rasterizer slice to the raster request arbiter:
// NUM_LANES stamps plus the slice's sticky done level.
interface VX_raster_bus_if
  import VX_raster_pkg::*;
  #(parameter int NUM_LANES = 4) ();

  typedef struct packed {
    raster_stamp_t [NUM_LANES-1:0] stamps;
    logic                          done;
  } req_data_t;

  logic      req_valid;
  req_data_t req_data;
  logic      req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);

endinterface

// File: rtl/raster_stamp_packer.sv
// Packs NUM_LANES stamps per arbiter request, flushes the partial packet at
// end-of-stream and then holds done high until the next frame start.
module raster_stamp_packer
  import VX_raster_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CTR_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  raster_stamp_t        in_stamp,
  input  logic                 in_done,
  output logic                 in_ready,
  VX_raster_bus_if.master      bus_out_if,
  output logic [CTR_W-1:0]     perf_stamps
);

  localparam int SLOT_N = (NUM_LANES > 1) ? NUM_LANES - 1 : 1;
  localparam int CNT_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_LANES - 1);

  packer_state_t                 state_reg, state_next;
  logic [CNT_W-1:0]              acc_count_reg, acc_count_next;
  raster_stamp_t                 slot_reg  [SLOT_N];
  raster_stamp_t                 slot_next [SLOT_N];
  raster_stamp_t [NUM_LANES-1:0] stamps_reg, stamps_next;
  raster_stamp_t [NUM_LANES-1:0] full_pkt, flush_pkt;
  logic                          req_valid_reg, req_valid_next;
  logic                          done_reg, done_next;
  logic [CTR_W-1:0]              perf_reg, perf_next;
  logic [MAX_LANES-1:0]          lane_active;
  logic                          out_free, out_fire, acc_full;

  assign out_fire = req_valid_reg & bus_out_if.req_ready;
  assign out_free = ~req_valid_reg | bus_out_if.req_ready;
  assign acc_full = (acc_count_reg == LAST_IDX);

  // Lane 0 is always the oldest stamp; the newest stamp bypasses the slots.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    if (gi < NUM_LANES - 1) begin : g_slot
      assign full_pkt[gi]  = slot_reg[gi];
      assign flush_pkt[gi] = (CNT_W'(gi) < acc_count_reg) ? slot_reg[gi] : '0;
    end else begin : g_last
      assign full_pkt[gi]  = in_stamp;
      assign flush_pkt[gi] = '0;
    end
    assign lane_active[gi] = |stamps_reg[gi].mask;
  end
  if (NUM_LANES < MAX_LANES) begin : g_pad
    assign lane_active[MAX_LANES-1:NUM_LANES] = '0;
  end

  always_comb begin
    state_next     = state_reg;
    acc_count_next = acc_count_reg;
    slot_next      = slot_reg;
    stamps_next    = stamps_reg;
    req_valid_next = req_valid_reg;
    done_next      = done_reg;
    perf_next      = perf_reg;
    in_ready       = 1'b0;

    if (out_fire) begin
      req_valid_next = 1'b0;
      perf_next      = perf_reg + CTR_W'(lane_count(lane_active));
    end

    unique case (state_reg)
      FILL: begin
        in_ready = reset & (~acc_full | out_free);
        if (in_valid & in_ready) begin
          if (acc_full) begin
            stamps_next    = full_pkt;
            done_next      = 1'b0;
            req_valid_next = 1'b1;
            acc_count_next = '0;
          end else begin
            slot_next[acc_count_reg] = in_stamp;
            acc_count_next           = acc_count_reg + CNT_W'(1);
          end
        end else if (in_done & ~in_valid) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (out_free) begin
          stamps_next    = flush_pkt;
          done_next      = 1'b1;
          req_valid_next = 1'b1;
          acc_count_next = '0;
          state_next     = DONE;
        end
      end
      DONE: begin
        // A start that arrives while the final packet is still stalled is
        // dropped so the pending request data never changes under the arbiter.
        if (start & out_free) begin
          done_next  = 1'b0;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= FILL;
      acc_count_reg <= '0;
      for (int i = 0; i < SLOT_N; i++) slot_reg[i] <= '0;
      stamps_reg    <= '0;
      req_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      perf_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      acc_count_reg <= acc_count_next;
      for (int i = 0; i < SLOT_N; i++) slot_reg[i] <= slot_next[i];
      stamps_reg    <= stamps_next;
      req_valid_reg <= req_valid_next;
      done_reg      <= done_next;
      perf_reg      <= perf_next;
    end
  end

  assign bus_out_if.req_valid = req_valid_reg;
  assign bus_out_if.req_data  = {stamps_reg, done_reg};
  assign perf_stamps          = perf_reg;

endmodule

// File: tb/tb_raster_stamp_packer.sv
// Scoreboard bench for raster_stamp_packer with NUM_LANES=4: expected packets
// are queued as stamps are accepted or flushed and popped on each handshake.
module tb_raster_stamp_packer;
  import VX_raster_pkg::*;

  localparam int NL = 4;
  localparam int CW = 32;
  localparam int SW = $bits(raster_stamp_t);
  localparam int PW = NL * SW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_done = 1'b0;
  raster_stamp_t in_stamp = '0;
  logic          in_ready;
  logic [CW-1:0] perf_stamps;

  VX_raster_bus_if #(.NUM_LANES(NL)) bus ();

  raster_stamp_packer #(.NUM_LANES(NL), .CTR_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_stamp    (in_stamp),
    .in_done     (in_done),
    .in_ready    (in_ready),
    .bus_out_if  (bus),
    .perf_stamps (perf_stamps)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] exp_q[$];
  raster_stamp_t model_acc[$];
  logic [CW-1:0] model_perf = '0;
  int            next_id = 0;
  int            cyc = 0;
  int            stall_until = 0;
  int            zero_mask_id = 20;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic raster_stamp_t make_stamp(input int id);
    raster_stamp_t s;
    s.pos_x = 12'(id * 3 + 1);
    s.pos_y = 12'(id * 5 + 2);
    s.mask  = (id == zero_mask_id) ? 4'h0 : 4'(id % 15 + 1);
    s.pid   = 8'(id + 1);
    return s;
  endfunction

  function automatic logic [PW-1:0] pack_pkt(input raster_stamp_t st[$], input logic done);
    raster_stamp_t [NL-1:0] arr;
    arr = '0;
    for (int i = 0; i < st.size(); i++) arr[i] = st[i];
    return {arr, done};
  endfunction

  function automatic logic [CW-1:0] pkt_lanes(input logic [PW-1:0] p);
    raster_stamp_t [NL-1:0] arr;
    logic [CW-1:0] n;
    arr = p[PW-1:1];
    n = '0;
    for (int i = 0; i < NL; i++) if (arr[i].mask != 4'h0) n++;
    return n;
  endfunction

  // Output-side back-pressure: req_ready low while cyc < stall_until.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    bus.req_ready = (cyc >= stall_until);
  end

  // Every cycle a request is presented it must match the queue head.
  always @(negedge clk) begin
    if (reset && bus.req_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pkt", 1, 0);
      end else begin
        check_eq("pkt_data", bus.req_data, exp_q[0]);
        if (bus.req_ready) begin
          $display("PKT lanes=%0d done=%0b data=%0h", pkt_lanes(exp_q[0]), exp_q[0][0], exp_q[0]);
          model_perf += pkt_lanes(exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_stamp(output bit stalled);
    raster_stamp_t s;
    int  waited;
    bit  got;
    s = make_stamp(next_id);
    next_id++;
    waited = 0;
    stalled = 0;
    got = 0;
    in_valid = 1'b1;
    in_stamp = s;
    while (!got && waited <= 100) begin
      @(negedge clk);
      if (in_ready) got = 1;
      else begin
        stalled = 1;
        waited++;
      end
    end
    if (!got) begin
      check_eq("accept_timeout", 0, 1);
    end else begin
      model_acc.push_back(s);
      if (model_acc.size() == NL) begin
        exp_q.push_back(pack_pkt(model_acc, 1'b0));
        model_acc.delete();
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    exp_q.push_back(pack_pkt(model_acc, 1'b1));
    model_acc.delete();
    in_done = 1'b1;
    @(posedge clk);
    #1;
    in_done = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit st;
    bit saw_stall;

    // Reset state, with a stamp offered to prove in_ready stays low.
    in_valid = 1'b1;
    in_stamp = make_stamp(99);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_valid", bus.req_valid, 0);
    check_eq("rst_done", bus.req_data.done, 0);
    check_eq("rst_perf", perf_stamps, 0);
    check_eq("rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);

    // 8 back-to-back stamps: two packets, in_ready never drops, N+1 latency.
    for (int i = 0; i < 8; i++) begin
      if (i == 3) check_eq("lat_before", bus.req_valid, 0);
      send_stamp(st);
      check_eq("b2b_no_stall", st, 0);
      if (i == 3) check_eq("lat_after", bus.req_valid, 1);
    end
    wait_drain();
    check_eq("perf_b2b", perf_stamps, model_perf);

    // 6 stamps then end-of-stream: full packet plus a zero-padded done packet.
    for (int i = 0; i < 6; i++) send_stamp(st);
    do_flush();
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check_eq("flush_req_valid", bus.req_valid, 0);
    check_eq("flush_done_sticky", bus.req_data.done, 1);
    check_eq("flush_in_ready", in_ready, 0);
    check_eq("perf_flush", perf_stamps, model_perf);

    // Frame restart: done clears the next cycle and FILL resumes.
    pulse_start();
    check_eq("start_done_clr", bus.req_data.done, 0);
    check_eq("start_in_ready", in_ready, 1);

    // End-of-stream with nothing accumulated still emits a done packet.
    do_flush();
    wait_drain();
    check_eq("empty_in_ready", in_ready, 0);
    check_eq("empty_done", bus.req_data.done, 1);
    check_eq("perf_empty", perf_stamps, model_perf);
    pulse_start();
    check_eq("restart2_done", bus.req_data.done, 0);

    // 12-stamp burst under a 10-cycle output stall, with start pulsed in FILL.
    stall_until = cyc + 10;
    saw_stall = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) start = 1'b1;
      send_stamp(st);
      start = 1'b0;
      saw_stall |= st;
    end
    check_eq("stall_backpressure", saw_stall, 1);
    wait_drain();
    check_eq("stall_done", bus.req_data.done, 0);
    check_eq("perf_stall", perf_stamps, model_perf);

    // Asynchronous reset while a request is stalled on the bus.
    stall_until = cyc + 1000;
    for (int i = 0; i < 5; i++) send_stamp(st);
    check_eq("pre_rst_valid", bus.req_valid, 1);
    in_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_req_valid", bus.req_valid, 0);
    check_eq("arst_done", bus.req_data.done, 0);
    check_eq("arst_perf", perf_stamps, 0);
    check_eq("arst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    exp_q.delete();
    model_acc.delete();
    model_perf = '0;
    stall_until = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rerst_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) send_stamp(st);
    wait_drain();
    check_eq("perf_after_rst", perf_stamps, model_perf);
    check_eq("after_rst_done", bus.req_data.done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raster_stamp_packer.md
Name: raster_stamp_packer

Overview:
- Sits directly upstream of the raster request arbiter, one instance per rasterizer slice.
- Accepts one raster_stamp_t per handshake from the slice's stamp generator.
- Packs NUM_LANES stamps into one VX_raster_bus_if request (stamps + done) and drives it to the arbiter input.
- Flushes a partial packet at end-of-stream, then holds a sticky done level; the arbiter's AND-reduction across slices depends on that level.

Parameters:
- NUM_LANES, 4, stamps per output request (>=1).
- CTR_W, 32, width of the emitted-stamp performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that begins a new frame; honoured only in DONE
- in_valid  in  1  stamp valid
- in_stamp  in  $bits(raster_stamp_t)  incoming stamp
- in_done  in  1  upstream exhausted; level
- in_ready  out  1  stamp accepted when in_valid & in_ready
- bus_out_if  master VX_raster_bus_if  req_valid / req_data.stamps[NUM_LANES] / req_data.done out, req_ready in
- perf_stamps  out  CTR_W  count of non-empty stamps delivered on bus_out_if since reset

Behaviour:
- Reset (reset==0, asynchronous):
  - state=FILL, acc_count=0, accumulator zeroed.
  - req_valid=0, req_data all zero, done=0, perf_stamps=0, in_ready=0 while asserted.
- Storage: accumulator of NUM_LANES-1 stamp slots plus acc_count (0..NUM_LANES-1), and one output register driving bus_out_if.
- Output register rules:
  - Output register is free when req_valid==0 or req_valid&req_ready this cycle.
  - Data is stable while req_valid & !req_ready.
- State FILL:
  - in_ready = (acc_count < NUM_LANES-1) | out_free.
  - Accepted stamp with acc_count < NUM_LANES-1: write slot[acc_count]; acc_count++.
  - Accepted stamp with acc_count == NUM_LANES-1: load {slots, in_stamp} into the output register, lane0 = oldest; done=0; req_valid=1 next cycle; acc_count=0.
  - Latency: last stamp accepted at cycle N gives req_valid at N+1. Sustained throughput is 1 stamp/cycle.
  - in_done==1 & in_valid==0: go to FLUSH. A valid stamp in the same cycle as in_done is accepted first; FLUSH is entered on a later cycle once in_valid==0.
- State FLUSH:
  - in_ready=0.
  - When the output register is free, load the accumulator slots (lanes >= acc_count zero-filled, i.e. mask=0) with done=1.
  - An empty accumulator still emits an all-zero packet with done=1.
  - acc_count=0; go to DONE.
- State DONE:
  - in_ready=0.
  - After the final packet handshakes, req_valid=0 and req_data.done stays 1, held until start.
  - start: clear done, return to FILL.
- start in FILL/FLUSH is ignored.
- perf_stamps: on each output handshake, add the number of lanes with non-zero mask. Wraps modulo 2^CTR_W.
- NUM_LANES==1: accumulator has no slots; every accepted stamp goes straight to the output register.
- Stamps are never dropped or reordered; lane order equals acceptance order.

Decomposition:
- raster_stamp_t stays in VX_raster_pkg.
- Add to VX_raster_pkg: the packer state enum (FILL, FLUSH, DONE) and a lane-count helper function (popcount of non-zero stamp masks).
- Accumulator and output register are inline; no sub-module is needed.
- The output register may be instantiated as VX_pipe_register with a ready-driven enable.

Test Plan:
- NUM_LANES=4: 8 stamps back-to-back with out_ready=1 -> 2 packets, lanes in order, done=0, first req_valid one cycle after stamp 4, in_ready never drops, perf_stamps=8.
- 6 stamps then in_done=1 -> packets {s0..s3,done=0} and {s4,s5,0,0,done=1}; done stays 1 after handshake; req_valid=0; perf_stamps=6.
- in_done=1 with empty accumulator -> single all-zero packet with done=1; in_ready=0 thereafter.
- Hold req_ready=0 for 10 cycles during 12-stamp burst -> in_ready drops once accumulator full and output pending, packet data stable, no loss; all 12 stamps delivered in order.
- start in DONE -> done clears next cycle, FILL resumes; next 4 stamps yield packet with done=0. Start pulsed in FILL -> no effect.
- Assert reset mid-burst with req_valid=1 -> req_valid, done, perf_stamps, acc_count zero immediately (asynchronously); after release, the packer restarts cleanly in FILL.
